// File: rtl/calc_result_formatter_if.sv
// Handshake bundle between the ALU result side and the display driver side
// of calc_result_formatter. master = producer/consumer environment, slave = formatter.
interface calc_result_formatter_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] result;
    logic        div_zero;
    logic        out_valid;
    logic        out_ready;
    logic        neg;
    logic        err;
    logic [19:0] bcd;
    logic [4:0]  digit_blank;

    modport master (
        output in_valid, result, div_zero, out_ready,
        input  in_ready, out_valid, neg, err, bcd, digit_blank
    );

    modport slave (
        input  in_valid, result, div_zero, out_ready,
        output in_ready, out_valid, neg, err, bcd, digit_blank
    );
endinterface

// File: rtl/calc_result_formatter.sv
// Signed 16-bit ALU result to sign + five BCD digits via 16-step double dabble.
// Optional leading-zero blanking mask is enabled by defining CALC_FMT_BLANK_EN.
module calc_result_formatter (
    input logic              clk,
    input logic              reset_n,
    calc_result_formatter_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                    state;
    logic [BCD_W-1:0]          acc;
    logic [DATA_W-1:0]         mag;
    logic [CNT_W-1:0]          count;
    logic [BCD_W-1:0]          adj_c;
    logic [BCD_W+DATA_W-1:0]   shifted_c;

`ifdef CALC_FMT_BLANK_EN
    // Blank every digit above the most-significant nonzero one; units never blanked.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] v);
        logic zero_above;
        blank_mask = '0;
        zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            zero_above    = zero_above && (v[4*i +: 4] == 4'd0);
            blank_mask[i] = zero_above;
        end
    endfunction
`endif

    // One double-dabble step: add-3 correction then shift {bcd, mag}.
    always_comb begin
        adj_c = acc;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        shifted_c = {adj_c, mag} << 1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            acc             <= '0;
            mag             <= '0;
            count           <= '0;
            bus.in_ready    <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.neg         <= 1'b0;
            bus.err         <= 1'b0;
            bus.bcd         <= '0;
            bus.digit_blank <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_ready && bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        if (bus.div_zero) begin
                            bus.err         <= 1'b1;
                            bus.neg         <= 1'b0;
                            bus.bcd         <= '0;
                            bus.digit_blank <= '0;
                            bus.out_valid   <= 1'b1;
                            state           <= DONE;
                        end else begin
                            bus.err <= 1'b0;
                            bus.neg <= bus.result[DATA_W-1];
                            // -32768 negates to itself, which reads correctly as unsigned 32768.
                            mag     <= bus.result[DATA_W-1] ? DATA_W'(~bus.result + 16'd1)
                                                            : bus.result;
                            acc     <= '0;
                            count   <= '0;
                            state   <= SHIFT;
                        end
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc   <= shifted_c[BCD_W+DATA_W-1:DATA_W];
                    mag   <= shifted_c[DATA_W-1:0];
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(15)) begin
                        bus.bcd       <= shifted_c[BCD_W+DATA_W-1:DATA_W];
                        bus.out_valid <= 1'b1;
`ifdef CALC_FMT_BLANK_EN
                        bus.digit_blank <= blank_mask(shifted_c[BCD_W+DATA_W-1:DATA_W]);
`else
                        bus.digit_blank <= '0;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calc_result_formatter.sv
// Directed self-checking bench for calc_result_formatter (works with or
// without CALC_FMT_BLANK_EN defined).
module tb_calc_result_formatter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

`ifdef CALC_FMT_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    calc_result_formatter_if bus ();

    calc_result_formatter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Present one value, return cycles until out_valid (-1 on timeout).
    task automatic send(input logic [15:0] v, input logic dz, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.result   = v;
        bus.div_zero = dz;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.neg, bus.err, bus.bcd, bus.digit_blank} !== 29'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b v=%b n=%b e=%b bcd=%h bl=%b want all 0",
                     bus.in_ready, bus.out_valid, bus.neg, bus.err, bus.bcd, bus.digit_blank);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_values();
        logic [15:0] vals [6] = '{16'd1234, 16'h8000, 16'hFFFF, 16'hFB2E, 16'd32767, 16'd9};
        logic [19:0] exp_bcd [6] = '{20'h01234, 20'h32768, 20'h00001, 20'h01234, 20'h32767, 20'h00009};
        logic        exp_neg [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [4:0]  exp_bl  [6] = '{5'b10000, 5'b00000, 5'b11110, 5'b10000, 5'b00000, 5'b11110};
        int lat;
        for (int i = 0; i < 6; i++) begin
            send(vals[i], 1'b0, lat);
            checks++;
            if (lat !== 17) begin
                failures++;
                $display("FAIL value_latency[%0d] got %0d want 17", i, lat);
            end
            checks++;
            if (bus.bcd !== exp_bcd[i] || bus.neg !== exp_neg[i] || bus.err !== 1'b0) begin
                failures++;
                $display("FAIL value[%0d] got bcd=%h neg=%b err=%b want bcd=%h neg=%b err=0",
                         i, bus.bcd, bus.neg, bus.err, exp_bcd[i], exp_neg[i]);
            end
            checks++;
            if (bus.digit_blank !== (BLANK ? exp_bl[i] : 5'b0)) begin
                failures++;
                $display("FAIL value_blank[%0d] got %b want %b", i, bus.digit_blank,
                         BLANK ? exp_bl[i] : 5'b0);
            end
            consume();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL value_handoff[%0d] got v=%b rdy=%b want v=0 rdy=1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        send(16'd0, 1'b1, lat);
        checks++;
        if (lat !== 1 || bus.err !== 1'b1 || bus.bcd !== 20'h0 || bus.neg !== 1'b0 || bus.digit_blank !== 5'b0) begin
            failures++;
            $display("FAIL div_zero got lat=%0d err=%b bcd=%h neg=%b bl=%b want lat=1 err=1 bcd=0 neg=0 bl=0",
                     lat, bus.err, bus.bcd, bus.neg, bus.digit_blank);
        end
        consume();
        send(16'd7, 1'b0, lat);
        checks++;
        if (lat !== 17 || bus.err !== 1'b0 || bus.bcd !== 20'h00007 || bus.neg !== 1'b0) begin
            failures++;
            $display("FAIL after_err got lat=%0d err=%b bcd=%h neg=%b want lat=17 err=0 bcd=00007 neg=0",
                     lat, bus.err, bus.bcd, bus.neg);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        send(16'd999, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = ~bus.in_valid;
            bus.result   = 16'($urandom);
            bus.div_zero = 1'($urandom);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.bcd !== 20'h00999 || bus.in_ready !== 1'b0 || bus.err !== 1'b0) begin
                failures++;
                $display("FAIL backpressure[%0d] got v=%b bcd=%h rdy=%b err=%b want v=1 bcd=00999 rdy=0 err=0",
                         c, bus.out_valid, bus.bcd, bus.in_ready, bus.err);
            end
        end
        bus.in_valid = 1'b0;
        consume();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        bus.in_valid = 1'b1;
        bus.result   = 16'd500;
        bus.div_zero = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if ({bus.out_valid, bus.neg, bus.err, bus.bcd, bus.digit_blank} !== 28'd0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs got v=%b n=%b e=%b bcd=%h bl=%b rdy=%b want all 0",
                     bus.out_valid, bus.neg, bus.err, bus.bcd, bus.digit_blank, bus.in_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_abort got seen_valid=%b rdy=%b want 0 1", seen, bus.in_ready);
        end
        send(16'd42, 1'b0, lat);
        checks++;
        if (lat !== 17 || bus.bcd !== 20'h00042 || bus.digit_blank !== (BLANK ? 5'b11100 : 5'b0)) begin
            failures++;
            $display("FAIL after_mid_reset got lat=%0d bcd=%h bl=%b want 17 00042 %b",
                     lat, bus.bcd, bus.digit_blank, BLANK ? 5'b11100 : 5'b0);
        end
        consume();
    endtask

    task automatic test_zero();
        int lat;
        send(16'd0, 1'b0, lat);
        checks++;
        if (lat !== 17 || bus.bcd !== 20'h0 || bus.neg !== 1'b0 || bus.err !== 1'b0
            || bus.digit_blank !== (BLANK ? 5'b11110 : 5'b0)) begin
            failures++;
            $display("FAIL zero got lat=%0d bcd=%h neg=%b err=%b bl=%b want 17 0 0 0 %b",
                     lat, bus.bcd, bus.neg, bus.err, bus.digit_blank, BLANK ? 5'b11110 : 5'b0);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        int start;
        int spacing;
        for (int k = 0; k < 3; k++) begin
            start = int'($time);
            send(16'd0, 1'b1, lat);
            consume();
            spacing = (int'($time) - start) / 10;
            checks++;
            if (lat !== 1 || bus.in_ready !== 1'b1 || spacing !== 2) begin
                failures++;
                $display("FAIL b2b_err[%0d] got lat=%0d rdy=%b spacing=%0d want 1 1 2",
                         k, lat, bus.in_ready, spacing);
            end
        end
        send(16'd65, 1'b0, lat);
        checks++;
        if (lat !== 17 || bus.bcd !== 20'h00065 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_normal got lat=%0d bcd=%h err=%b want 17 00065 0", lat, bus.bcd, bus.err);
        end
        consume();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.result    = 16'd0;
        bus.div_zero  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_values();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
